// File: rtl/life_pkg.sv
// ----------------------------------------------------------------------------
// life_pkg
// Shared constants and types for the 8x8 Game-of-Life generation engine.
//   COLS, ROWS, CELLS : board geometry
//   SEED              : power-on board (the "HW" pattern), bit i = cell i
//   state_e           : generation FSM states
// ----------------------------------------------------------------------------
package life_pkg;

    localparam int COLS  = 8;
    localparam int ROWS  = 8;
    localparam int CELLS = COLS * ROWS;

    // Cells {3,6,8,12,19,22,24,28,35,38,40,42,44,52,53,57,59}
    localparam logic [CELLS-1:0] SEED = 64'h0A30_1548_1148_1148;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP
    } state_e;

endpackage

// File: rtl/life_cell_rule.sv
// ----------------------------------------------------------------------------
// life_cell_rule
// Combinational Conway rule for one cell.
// Ports:
//   alive_i      : current state of the cell
//   nbrs_i[7:0]  : the eight neighbour states (off-board already forced dead)
//   next_alive_o : cell state in the next generation
// ----------------------------------------------------------------------------
module life_cell_rule (
    input  logic       alive_i,
    input  logic [7:0] nbrs_i,
    output logic       next_alive_o
);

    logic [3:0] nbr_cnt;

    // NOTE: every always_comb output gets a default before any branch or loop,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        nbr_cnt = '0;
        for (int k = 0; k < 8; k++) begin
            nbr_cnt = nbr_cnt + 4'(nbrs_i[k]);
        end
        // Birth on exactly 3; survival on 2 or 3.
        next_alive_o = (nbr_cnt == 4'd3) || (alive_i && (nbr_cnt == 4'd2));
    end

endmodule

// File: rtl/life_gen_engine.sv
// ----------------------------------------------------------------------------
// life_gen_engine
// Holds the displayed 8x8 board and computes the next generation one cell per
// cycle into a work buffer, then swaps it in on a single edge so the renderer
// never sees a partially updated board.
//
// Ports:
//   clk        : pixel clock
//   reset      : synchronous, active-high reset
//   frame_tick : one-cycle pulse per video frame
//   run        : advance automatically every GEN_FRAMES frame ticks
//   step       : one-cycle pulse, request one generation when idle
//   seed_load  : one-cycle pulse, load seed_data into the displayed board
//   seed_data  : board to load, bit i = cell i
//   rd_addr    : renderer cell index, row*8 + col
//   rd_data    : displayed cell at rd_addr (combinational)
//   busy       : generation in progress
//   gen_done   : one-cycle pulse when a new board becomes visible
//   generation : generations since reset/load, wraps at 16 bits
//
// Build option: define LIFE_TORUS_EN to wrap neighbours modulo the board size
// in both axes; otherwise off-board neighbours read as dead.
// ----------------------------------------------------------------------------
module life_gen_engine
    import life_pkg::*;
#(
    parameter int COLS_LOG2  = $clog2(COLS),
    parameter int ROWS_LOG2  = $clog2(ROWS),
    parameter int GEN_FRAMES = 60
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic                                  run,
    input  logic                                  step,
    input  logic                                  seed_load,
    input  logic [(1<<(COLS_LOG2+ROWS_LOG2))-1:0] seed_data,
    input  logic [COLS_LOG2+ROWS_LOG2-1:0]        rd_addr,
    output logic                                  rd_data,
    output logic                                  busy,
    output logic                                  gen_done,
    output logic [15:0]                           generation
);

    localparam int N_W     = COLS_LOG2 + ROWS_LOG2;
    localparam int N_CELLS = 1 << N_W;

`ifdef LIFE_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    state_e               state_q,      state_d;
    logic [N_W-1:0]       idx_q,        idx_d;
    logic [5:0]           frame_cnt_q,  frame_cnt_d;
    logic [15:0]          generation_q, generation_d;
    logic [N_CELLS-1:0]   display_q,    display_d;
    logic [N_CELLS-1:0]   work_q,       work_d;
    logic                 gen_done_q,   gen_done_d;

    // ------------------------------------------------------------------
    // Neighbour gather for the cell being computed (always from display).
    // Row/column arithmetic wraps naturally in its own width; the *_ok
    // flags kill the wrapped reads on a dead-border board.
    // ------------------------------------------------------------------
    logic [ROWS_LOG2-1:0] cur_row, row_up, row_dn;
    logic [COLS_LOG2-1:0] cur_col, col_lf, col_rt;
    logic                 up_ok, dn_ok, lf_ok, rt_ok;
    logic [7:0]           nbrs;
    logic                 next_cell;

    always_comb begin
        cur_row = idx_q[N_W-1:COLS_LOG2];
        cur_col = idx_q[COLS_LOG2-1:0];
        row_up  = cur_row - ROWS_LOG2'(1);
        row_dn  = cur_row + ROWS_LOG2'(1);
        col_lf  = cur_col - COLS_LOG2'(1);
        col_rt  = cur_col + COLS_LOG2'(1);

        up_ok = TORUS || (cur_row != '0);
        dn_ok = TORUS || (cur_row != '1);
        lf_ok = TORUS || (cur_col != '0);
        rt_ok = TORUS || (cur_col != '1);

        nbrs[0] = up_ok && lf_ok && display_q[{row_up,  col_lf }];
        nbrs[1] = up_ok          && display_q[{row_up,  cur_col}];
        nbrs[2] = up_ok && rt_ok && display_q[{row_up,  col_rt }];
        nbrs[3] = lf_ok          && display_q[{cur_row, col_lf }];
        nbrs[4] = rt_ok          && display_q[{cur_row, col_rt }];
        nbrs[5] = dn_ok && lf_ok && display_q[{row_dn,  col_lf }];
        nbrs[6] = dn_ok          && display_q[{row_dn,  cur_col}];
        nbrs[7] = dn_ok && rt_ok && display_q[{row_dn,  col_rt }];
    end

    life_cell_rule u_rule (
        .alive_i      (display_q[idx_q]),
        .nbrs_i       (nbrs),
        .next_alive_o (next_cell)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic auto_start;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        generation_d = generation_q;
        display_d    = display_q;
        work_d       = work_q;
        gen_done_d   = 1'b0;
        auto_start   = 1'b0;

        if (seed_load) begin
            // Overrides everything, including an in-flight generation.
            display_d    = seed_data;
            work_d       = '0;
            state_d      = IDLE;
            idx_d        = '0;
            generation_d = '0;
            frame_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    auto_start = run && frame_tick &&
                                 (frame_cnt_q == 6'(GEN_FRAMES - 1));
                    if (run && frame_tick) begin
                        frame_cnt_d = frame_cnt_q + 6'd1;
                    end
                    // step and an automatic start on the same edge merge
                    // into one generation.
                    if (step || auto_start) begin
                        state_d     = COMPUTE;
                        idx_d       = '0;
                        frame_cnt_d = '0;
                    end
                end
                COMPUTE: begin
                    work_d[idx_q] = next_cell;
                    idx_d         = idx_q + N_W'(1);
                    if (idx_q == '1) begin
                        state_d = SWAP;
                    end
                end
                SWAP: begin
                    display_d    = work_q;
                    generation_d = generation_q + 16'd1;
                    gen_done_d   = 1'b1;
                    state_d      = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: both boards are flop arrays, not RAM; the displayed board's reset
    // value is functional (the power-on pattern), so both are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            generation_q <= '0;
            display_q    <= SEED;
            work_q       <= '0;
            gen_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            generation_q <= generation_d;
            display_q    <= display_d;
            work_q       <= work_d;
            gen_done_q   <= gen_done_d;
        end
    end

    assign rd_data    = display_q[rd_addr];
    assign busy       = (state_q != IDLE);
    assign gen_done   = gen_done_q;
    assign generation = generation_q;

endmodule
